// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF layer: FSM states, load
// selector codes, config-byte field layout, reset constants and saturation.
package lif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } lif_state_e;

    localparam logic [1:0] SEL_INPUTS    = 2'd0;
    localparam logic [1:0] SEL_WEIGHTS   = 2'd1;
    localparam logic [1:0] SEL_THRESHOLD = 2'd2;
    localparam logic [1:0] SEL_CONFIG    = 2'd3;

    localparam int SHIFT_LSB   = 0;
    localparam int SHIFT_W     = 3;
    localparam int REFRACT_LSB = 4;
    localparam int REFRACT_W   = 4;

    localparam int   THRESHOLD_INIT  = 5;
    localparam logic WEIGHT_INIT_BIT = 1'b1;

    // Clamp a signed value into the range of a signed field of width bits.
    function automatic int sat_signed(input int value, input int bits);
        int hi;
        int lo;
        hi = (1 <<< (bits - 1)) - 1;
        lo = -(1 <<< (bits - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/lif_layer_tdm_if.sv
// Byte-wide load bus plus step/busy/done handshake of the LIF layer.
interface lif_layer_tdm_if #(
    parameter int N_NEURONS     = 4,
    parameter int MEMBRANE_BITS = 8
);
    logic [7:0]                      data_in;
    logic                            data_valid;
    logic [1:0]                      data_sel;
    logic                            step;
    logic                            busy;
    logic                            done;
    logic [N_NEURONS-1:0]            spikes;
    logic signed [MEMBRANE_BITS-1:0] membrane_out;

    modport master (
        output data_in, data_valid, data_sel, step,
        input  busy, done, spikes, membrane_out
    );

    modport slave (
        input  data_in, data_valid, data_sel, step,
        output busy, done, spikes, membrane_out
    );
endinterface

// File: rtl/lif_update.sv
// Combinational single-neuron update: binary-weighted input sum, arithmetic
// leak, saturation, threshold compare and reset-by-subtraction.
module lif_update
    import lif_pkg::*;
#(
    parameter int N_INPUTS       = 16,
    parameter int MEMBRANE_BITS  = 8,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
    input  logic [N_INPUTS-1:0]             inputs,
    input  logic [N_INPUTS-1:0]             weight_row,
    input  logic signed [MEMBRANE_BITS-1:0] membrane,
    input  logic [SHIFT_W-1:0]              shift,
    input  logic [THRESHOLD_BITS-1:0]       threshold,
    input  logic                            refractory,
    output logic signed [MEMBRANE_BITS-1:0] membrane_next,
    output logic                            spike
);
    // Two guard bits cover m - leak + sum while N_INPUTS stays below the membrane range.
    localparam int RAW_W = MEMBRANE_BITS + 2;
    localparam logic signed [RAW_W-1:0] PLUS_ONE  = RAW_W'(1);
    localparam logic signed [RAW_W-1:0] MINUS_ONE = RAW_W'(-1);

    logic signed [RAW_W-1:0] contrib [N_INPUTS];

    generate
        for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_contrib
            assign contrib[gi] = inputs[gi] ? (weight_row[gi] ? PLUS_ONE : MINUS_ONE) : '0;
        end
    endgenerate

    logic signed [RAW_W-1:0]         sum;
    logic signed [RAW_W-1:0]         mem_ext;
    logic signed [RAW_W-1:0]         leak;
    logic signed [RAW_W-1:0]         raw;
    logic signed [RAW_W-1:0]         thr_ext;
    logic signed [MEMBRANE_BITS-1:0] thr_mem;
    logic signed [MEMBRANE_BITS-1:0] sat_mem;
    int                              sat_int;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            sum = sum + contrib[i];
        end
        if (refractory) begin
            sum = '0;
        end
        mem_ext = {{2{membrane[MEMBRANE_BITS-1]}}, membrane};
        leak    = (shift == '0) ? '0 : (mem_ext >>> shift);
        raw     = mem_ext - leak + sum;
        thr_ext = RAW_W'(threshold);
        thr_mem = MEMBRANE_BITS'(threshold);
        sat_int = sat_signed(int'(raw), MEMBRANE_BITS);
        sat_mem = sat_int[MEMBRANE_BITS-1:0];
        spike   = !refractory && (raw >= thr_ext);
        membrane_next = spike ? (sat_mem - thr_mem) : sat_mem;
    end

endmodule

// File: rtl/lif_layer_tdm.sv
// Layer of N_NEURONS LIF neurons sharing one input vector; a single update
// datapath sweeps the neurons one per cycle on each step command.
module lif_layer_tdm
    import lif_pkg::*;
#(
    parameter int N_INPUTS       = 16,
    parameter int N_NEURONS      = 4,
    parameter int MEMBRANE_BITS  = 8,
    parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1
) (
    input  logic            clk,
    input  logic            reset,
    lif_layer_tdm_if.slave  bus
);
    localparam int N_WEIGHTS = N_NEURONS * N_INPUTS;
    localparam int IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e                      state_reg;
    logic [IDX_W-1:0]                idx_reg;
    logic [N_INPUTS-1:0]             inputs_reg;
    logic [N_WEIGHTS-1:0]            weights_reg;
    logic [THRESHOLD_BITS-1:0]       threshold_reg;
    logic [SHIFT_W-1:0]              shift_reg;
    logic [REFRACT_W-1:0]            refract_reg;
    logic signed [MEMBRANE_BITS-1:0] membrane_reg [N_NEURONS];
    logic [REFRACT_W-1:0]            refr_reg [N_NEURONS];
    logic [N_NEURONS-1:0]            spike_buf_reg;
    logic [N_NEURONS-1:0]            spikes_reg;
    logic                            busy_reg;
    logic                            done_reg;
    logic signed [MEMBRANE_BITS-1:0] membrane_hold_reg;

    logic [N_INPUTS-1:0] weight_rows [N_NEURONS];

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_rows
            assign weight_rows[gi] = weights_reg[gi*N_INPUTS +: N_INPUTS];
        end
    endgenerate

    // Byte shift-in at the LSB; the widened concat drops bits above the register width.
    logic [N_INPUTS+7:0]  inputs_shifted;
    logic [N_WEIGHTS+7:0] weights_shifted;
    assign inputs_shifted  = {inputs_reg, bus.data_in};
    assign weights_shifted = {weights_reg, bus.data_in};

    logic load_en;
    assign load_en = bus.data_valid && (state_reg != ST_RUN);

    logic [REFRACT_W-1:0]            cur_refr;
    logic signed [MEMBRANE_BITS-1:0] upd_mem;
    logic                            upd_spike;
    logic [N_NEURONS-1:0]            spike_buf_next;

    assign cur_refr = refr_reg[idx_reg];

    lif_update #(
        .N_INPUTS       (N_INPUTS),
        .MEMBRANE_BITS  (MEMBRANE_BITS),
        .THRESHOLD_BITS (THRESHOLD_BITS)
    ) u_update (
        .inputs        (inputs_reg),
        .weight_row    (weight_rows[idx_reg]),
        .membrane      (membrane_reg[idx_reg]),
        .shift         (shift_reg),
        .threshold     (threshold_reg),
        .refractory    (cur_refr != '0),
        .membrane_next (upd_mem),
        .spike         (upd_spike)
    );

    always_comb begin
        spike_buf_next          = spike_buf_reg;
        spike_buf_next[idx_reg] = upd_spike;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            idx_reg           <= '0;
            inputs_reg        <= '0;
            weights_reg       <= {N_WEIGHTS{WEIGHT_INIT_BIT}};
            threshold_reg     <= THRESHOLD_BITS'(THRESHOLD_INIT);
            shift_reg         <= '0;
            refract_reg       <= '0;
            spike_buf_reg     <= '0;
            spikes_reg        <= '0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            membrane_hold_reg <= '0;
            for (int n = 0; n < N_NEURONS; n++) begin
                membrane_reg[n] <= '0;
                refr_reg[n]     <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            if (load_en) begin
                case (bus.data_sel)
                    SEL_INPUTS:    inputs_reg    <= inputs_shifted[N_INPUTS-1:0];
                    SEL_WEIGHTS:   weights_reg   <= weights_shifted[N_WEIGHTS-1:0];
                    SEL_THRESHOLD: threshold_reg <= THRESHOLD_BITS'(bus.data_in);
                    default: begin
                        shift_reg   <= bus.data_in[SHIFT_LSB +: SHIFT_W];
                        refract_reg <= bus.data_in[REFRACT_LSB +: REFRACT_W];
                    end
                endcase
            end
            case (state_reg)
                ST_IDLE: begin
                    if (bus.step) begin
                        state_reg <= ST_RUN;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    membrane_reg[idx_reg] <= upd_mem;
                    membrane_hold_reg     <= upd_mem;
                    if (upd_spike) begin
                        refr_reg[idx_reg] <= refract_reg;
                    end else if (cur_refr != '0) begin
                        refr_reg[idx_reg] <= cur_refr - REFRACT_W'(1);
                    end
                    spike_buf_reg <= spike_buf_next;
                    if (idx_reg == LAST_IDX) begin
                        state_reg  <= ST_DONE;
                        busy_reg   <= 1'b0;
                        done_reg   <= 1'b1;
                        spikes_reg <= spike_buf_next;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.spikes       = spikes_reg;
    assign bus.membrane_out = (state_reg == ST_RUN) ? upd_mem : membrane_hold_reg;

endmodule

// File: tb/tb_lif_layer_tdm.sv
// Scoreboard bench for lif_layer_tdm: stimulus pushes expected membranes and
// spike vectors; a negedge monitor pops and compares as the layer presents them.
module tb_lif_layer_tdm;
    localparam int N_INPUTS  = 16;
    localparam int N_NEURONS = 4;
    localparam int MB        = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lif_layer_tdm_if #(.N_NEURONS(N_NEURONS), .MEMBRANE_BITS(MB)) bus();

    lif_layer_tdm #(
        .N_INPUTS      (N_INPUTS),
        .N_NEURONS     (N_NEURONS),
        .MEMBRANE_BITS (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    n_cmp  = 0;
    int    n_bad  = 0;
    bit    mon_en = 1'b1;
    string phase  = "reset";

    logic signed [MB-1:0]    exp_mem_q [$];
    logic [N_NEURONS-1:0]    exp_spk_q [$];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s %s: got %0d required %0d", phase, name, act, req);
        end
    endtask

    // Monitor: one membrane per busy cycle, one spike vector per done pulse.
    always @(negedge clk) begin : monitor
        logic signed [MB-1:0] e_mem;
        logic [N_NEURONS-1:0] e_spk;
        if (mon_en && !reset) begin
            if (bus.busy) begin
                if (exp_mem_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    e_mem = exp_mem_q.pop_front();
                    check("membrane_out", $signed(bus.membrane_out), e_mem);
                end
            end
            if (bus.done) begin
                if (exp_spk_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e_spk = exp_spk_q.pop_front();
                    check("spikes", bus.spikes, e_spk);
                    $display("sweep %s: spikes=%b required=%b", phase, bus.spikes, e_spk);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] b);
        @(negedge clk);
        bus.data_valid = 1'b1;
        bus.data_sel   = sel;
        bus.data_in    = b;
        @(negedge clk);
        bus.data_valid = 1'b0;
    endtask

    // One sweep; hold keeps step high through done, push drives weight bytes while busy.
    task automatic run_step(input logic signed [MB-1:0] m0, input logic signed [MB-1:0] m1,
                            input logic signed [MB-1:0] m2, input logic signed [MB-1:0] m3,
                            input logic [N_NEURONS-1:0] spk, input bit hold, input bit push);
        int lat;
        exp_mem_q.push_back(m0);
        exp_mem_q.push_back(m1);
        exp_mem_q.push_back(m2);
        exp_mem_q.push_back(m3);
        exp_spk_q.push_back(spk);
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        if (!hold) bus.step = 1'b0;
        check("busy_t1", bus.busy, 1);
        lat = 1;
        while (!bus.done && lat < 20) begin
            bus.data_valid = push && (lat <= N_NEURONS);
            bus.data_sel   = 2'd1;
            bus.data_in    = 8'h00;
            @(negedge clk);
            lat++;
        end
        bus.data_valid = 1'b0;
        check("done_latency", lat, N_NEURONS + 1);
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic count_quiet(input string name, input int cycles);
        int extra;
        extra = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done || bus.busy) extra++;
        end
        check(name, extra, 0);
    endtask

    logic signed [MB-1:0] sat_tab  [9] = '{-16, -32, -48, -64, -80, -96, -112, -128, -128};
    logic signed [MB-1:0] leak_tab [6] = '{8, 12, 14, 15, 16, 16};

    initial begin
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.data_sel   = '0;
        bus.step       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_spikes", bus.spikes, 0);
        check("rst_membrane_out", $signed(bus.membrane_out), 0);
        reset = 1'b0;

        phase = "basic";
        load(2'd0, 8'h00);
        load(2'd0, 8'hFF);
        run_step(3, 3, 3, 3, 4'b1111, 1'b0, 1'b0);

        phase = "row1_zero";
        do_reset();
        load(2'd1, 8'hFF); load(2'd1, 8'hFF); load(2'd1, 8'hFF); load(2'd1, 8'hFF);
        load(2'd1, 8'h00); load(2'd1, 8'h00); load(2'd1, 8'hFF); load(2'd1, 8'hFF);
        load(2'd0, 8'h00);
        load(2'd0, 8'hFF);
        run_step(3, -8, 3, 3, 4'b1101, 1'b0, 1'b0);

        phase = "busy_push";
        run_step(6, -16, 6, 6, 4'b1101, 1'b0, 1'b1);
        run_step(9, -24, 9, 9, 4'b1101, 1'b0, 1'b0);

        phase = "step_hold";
        run_step(12, -32, 12, 12, 4'b1101, 1'b1, 1'b0);
        count_quiet("extra_sweep", 10);

        phase = "reset_mid";
        mon_en = 1'b0;
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        check("busy_before_reset", bus.busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("busy_after_reset", bus.busy, 0);
        check("spikes_after_reset", bus.spikes, 0);
        count_quiet("no_done_after_reset", 10);
        mon_en = 1'b1;

        phase = "saturate";
        do_reset();
        for (int i = 0; i < 8; i++) load(2'd1, 8'h00);
        load(2'd0, 8'hFF);
        load(2'd0, 8'hFF);
        for (int k = 0; k < 9; k++) begin
            run_step(sat_tab[k], sat_tab[k], sat_tab[k], sat_tab[k], 4'b0000, 1'b0, 1'b0);
        end

        phase = "refract";
        do_reset();
        load(2'd0, 8'h00);
        load(2'd0, 8'hFF);
        load(2'd3, 8'h20);
        run_step(3, 3, 3, 3, 4'b1111, 1'b0, 1'b0);
        run_step(3, 3, 3, 3, 4'b0000, 1'b0, 1'b0);
        run_step(3, 3, 3, 3, 4'b0000, 1'b0, 1'b0);
        run_step(6, 6, 6, 6, 4'b1111, 1'b0, 1'b0);

        phase = "leak";
        do_reset();
        load(2'd0, 8'h00);
        load(2'd0, 8'hFF);
        load(2'd2, 8'h3F);
        load(2'd3, 8'h01);
        for (int k = 0; k < 6; k++) begin
            run_step(leak_tab[k], leak_tab[k], leak_tab[k], leak_tab[k], 4'b0000, 1'b0, 1'b0);
        end

        phase = "end";
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_mem_q.size() + exp_spk_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
